// File: rtl/scan_decoder.sv
// SEL_W-to-2^SEL_W decoder with registered one-hot active-low outputs and an
// auto-scan mode that steps through the first NUM_OUT outputs every PRESCALE enabled cycles.
module scan_decoder #(
    parameter int SEL_W    = 2,
    parameter int NUM_OUT  = 4,
    parameter int PRESCALE = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    G_L,
    input  logic                    MODE,
    input  logic [SEL_W-1:0]        SEL,
    output logic [(1<<SEL_W)-1:0]   Y_L,
    output logic [SEL_W-1:0]        IDX,
    output logic                    WRAP
);
    localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [SEL_W-1:0] idx_reg, idx_next;
    logic [PC_W-1:0]  pc_reg, pc_next;
    logic             en_q_reg;
    logic             wrap_reg, wrap_next;

    always_comb begin
        idx_next  = idx_reg;
        pc_next   = pc_reg;
        wrap_next = 1'b0;
        if (!G_L) begin
            if (!MODE) begin
                idx_next = SEL;
                pc_next  = '0;
            end else if (pc_reg != PC_W'(PRESCALE - 1)) begin
                pc_next = pc_reg + PC_W'(1);
            end else begin
                pc_next = '0;
                // Out-of-range indices left over from direct mode also wrap here.
                if (int'(idx_reg) >= NUM_OUT - 1) begin
                    idx_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    idx_next = idx_reg + SEL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            idx_reg  <= '0;
            pc_reg   <= '0;
            en_q_reg <= 1'b0;
            wrap_reg <= 1'b0;
        end else begin
            idx_reg  <= idx_next;
            pc_reg   <= pc_next;
            en_q_reg <= ~G_L;
            wrap_reg <= wrap_next;
        end
    end

    // Outputs decode registers only, so input changes can never glitch them.
    genvar gi;
    generate
        for (gi = 0; gi < (1 << SEL_W); gi++) begin : g_dec
            if (gi < NUM_OUT) begin : g_used
                assign Y_L[gi] = ~(en_q_reg && (idx_reg == SEL_W'(gi)));
            end else begin : g_unused
                assign Y_L[gi] = 1'b1;
            end
        end
    endgenerate

    assign IDX  = idx_reg;
    assign WRAP = wrap_reg;

endmodule
